// File: rtl/wave_ram_reader_if.sv
// Signal bundle between the waveform RAM reader, the capture RAM read port
// and the HDMI column plotter.
interface wave_ram_reader_if;
    // Column handshake: Col_Req is a one-cycle request with no backpressure.
    // It is taken only while Ready=1, Col_X<H_ACTIVE and Frame_Start is low.
    // Each taken request yields exactly one Sample_Valid pulse, in request order.
    logic        Frame_Start;
    logic [7:0]  Trigger_Gate;
    logic [3:0]  Decim;
    logic [7:0]  Ram_Data;
    logic [17:0] Read_Addr;
    logic        Col_Req;
    logic [10:0] Col_X;
    logic [7:0]  Sample_Out;
    logic        Sample_Valid;
    logic        Ready;
    logic        Trig_Found;

    modport master (
        output Frame_Start, Trigger_Gate, Decim, Ram_Data, Col_Req, Col_X,
        input  Read_Addr, Sample_Out, Sample_Valid, Ready, Trig_Found
    );

    modport slave (
        input  Frame_Start, Trigger_Gate, Decim, Ram_Data, Col_Req, Col_X,
        output Read_Addr, Sample_Out, Sample_Valid, Ready, Trig_Found
    );
endinterface

// File: rtl/wave_ram_reader.sv
// Per-frame rising-edge trigger search over the capture RAM, then pipelined
// per-column sample reads starting at the trigger address.
module wave_ram_reader #(
    parameter int SAMPLING_NUM = 20000,
    parameter int SEARCH_LEN   = 4000,
    parameter int H_ACTIVE     = 1280,
    parameter int RAM_LAT      = 1
) (
    input  logic             clk_system,
    input  logic             Rst,
    wave_ram_reader_if.slave bus,
    output logic [1:0]       dbg_state   // 0 = IDLE, 1 = SEARCH, 2 = SERVE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SERVE  = 2'd2
    } state_t;

    localparam logic [17:0] LAST_SCAN = 18'(SEARCH_LEN - 1);
    localparam logic [17:0] WRAP_SUB  = 18'(SAMPLING_NUM);
    localparam logic [11:0] COL_LIMIT = 12'(H_ACTIVE);

    state_t state;
    state_t state_next;

    logic [17:0] read_addr_q;
    logic [17:0] trig_addr_q;
    logic        trig_found_q;
    logic        ready_q;
    logic [7:0]  sample_q;
    logic        sample_valid_q;
    logic [7:0]  prev_q;
    logic        prev_vld;

    // Bit 0 of each valid pipe lines up with read_addr_q; bit RAM_LAT with Ram_Data.
    logic [RAM_LAT:0] scn_vld;
    logic [RAM_LAT:0] srv_vld;
    logic [17:0]      scn_tag [1:RAM_LAT];

    logic        scan_more;
    logic        ret_vld;
    logic [17:0] ret_tag;
    logic        hit;
    logic        exhausted;
    logic        accept;
    logic [3:0]  decim_eff;
    logic [14:0] step_prod;
    logic [17:0] addr_sum;
    logic [17:0] addr_wrap;

    always_comb begin
        scan_more = (read_addr_q < LAST_SCAN);
        ret_vld   = (state == SEARCH) && scn_vld[RAM_LAT];
        ret_tag   = scn_tag[RAM_LAT];
        // A zero gate can never satisfy prev < gate, so it never triggers.
        hit       = ret_vld && prev_vld &&
                    (prev_q < bus.Trigger_Gate) && (bus.Ram_Data >= bus.Trigger_Gate);
        exhausted = ret_vld && !hit && (ret_tag == LAST_SCAN);
        accept    = (state == SERVE) && bus.Col_Req && !bus.Frame_Start &&
                    ({1'b0, bus.Col_X} < COL_LIMIT);
        decim_eff = (bus.Decim == 4'd0) ? 4'd1 : bus.Decim;
        step_prod = 15'(bus.Col_X) * 15'(decim_eff);
        addr_sum  = trig_addr_q + 18'(step_prod);
        // Legal configurations keep addr_sum below 2*SAMPLING_NUM, so one subtract suffices.
        addr_wrap = (addr_sum >= WRAP_SUB) ? (addr_sum - WRAP_SUB) : addr_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.Frame_Start) state_next = SEARCH;
            end
            SEARCH: begin
                if (bus.Frame_Start)        state_next = SEARCH;
                else if (hit || exhausted)  state_next = SERVE;
            end
            SERVE: begin
                if (bus.Frame_Start) state_next = SEARCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_system) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk_system) begin
        if (Rst) begin
            read_addr_q    <= '0;
            trig_addr_q    <= '0;
            trig_found_q   <= 1'b0;
            ready_q        <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            prev_q         <= '0;
            prev_vld       <= 1'b0;
            scn_vld        <= '0;
            srv_vld        <= '0;
        end else begin
            ready_q <= (state_next == SERVE);
            if (bus.Frame_Start) begin
                // Restart the scan at address 0 and drop everything in flight.
                read_addr_q    <= '0;
                scn_vld        <= {{RAM_LAT{1'b0}}, 1'b1};
                srv_vld        <= '0;
                prev_vld       <= 1'b0;
                sample_valid_q <= 1'b0;
            end else begin
                sample_valid_q <= srv_vld[RAM_LAT];
                if (srv_vld[RAM_LAT]) sample_q <= bus.Ram_Data;
                srv_vld <= {srv_vld[RAM_LAT-1:0], accept};
                if (state == SEARCH) begin
                    if (scan_more) read_addr_q <= read_addr_q + 18'd1;
                    scn_vld <= (state_next == SEARCH) ? {scn_vld[RAM_LAT-1:0], scan_more} : '0;
                    if (ret_vld) begin
                        prev_q   <= bus.Ram_Data;
                        prev_vld <= 1'b1;
                    end
                    if (hit) begin
                        trig_addr_q  <= ret_tag;
                        trig_found_q <= 1'b1;
                    end else if (exhausted) begin
                        trig_addr_q  <= '0;
                        trig_found_q <= 1'b0;
                    end
                end else begin
                    scn_vld <= '0;
                    if (accept) read_addr_q <= addr_wrap;
                end
            end
        end
    end

    // Address tags travel alongside the scan valids; they carry no reset.
    always_ff @(posedge clk_system) begin
        scn_tag[1] <= read_addr_q;
        for (int k = 2; k <= RAM_LAT; k++) scn_tag[k] <= scn_tag[k-1];
    end

    assign bus.Read_Addr    = read_addr_q;
    assign bus.Sample_Out   = sample_q;
    assign bus.Sample_Valid = sample_valid_q;
    assign bus.Ready        = ready_q;
    assign bus.Trig_Found   = trig_found_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_wave_ram_reader.sv
// Bench for wave_ram_reader: behavioural RAM, trigger/address reference model,
// table-driven serve vectors, directed corner sequences and random frames.
module tb_wave_ram_reader;

    localparam int SAMPLING_NUM = 20000;
    localparam int SEARCH_LEN   = 4000;
    localparam int H_ACTIVE     = 1280;
    localparam int RAM_LAT      = 1;
    localparam int SEARCH_BOUND = SEARCH_LEN + RAM_LAT + 1;
    localparam int SERVE_LAT    = 2 + RAM_LAT;

    logic       clk_system = 1'b0;
    logic       Rst = 1'b1;
    logic [1:0] dbg_state;

    wave_ram_reader_if bus();

    wave_ram_reader #(
        .SAMPLING_NUM(SAMPLING_NUM),
        .SEARCH_LEN  (SEARCH_LEN),
        .H_ACTIVE    (H_ACTIVE),
        .RAM_LAT     (RAM_LAT)
    ) dut (
        .clk_system(clk_system),
        .Rst       (Rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    always #5 clk_system = ~clk_system;

    int cyc = 0;
    always @(posedge clk_system) cyc <= cyc + 1;

    logic [7:0] mem [SAMPLING_NUM];
    always @(posedge clk_system)
        bus.Ram_Data <= (int'(bus.Read_Addr) < SAMPLING_NUM) ? mem[int'(bus.Read_Addr)] : 8'h00;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [39:0] exp_q[$];   // {due cycle, sample}

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk_system) begin : monitor
        logic [39:0] e;
        if (bus.Sample_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sample_out", bus.Sample_Out, e[7:0]);
                check("sample_latency", cyc, e[39:8]);
            end
        end
    end

    // ---------------- reference model ----------------
    bit m_serve;
    bit m_found;
    bit m_addr_known;
    int m_trig;
    int m_addr;
    int m_pend;

    function automatic int find_trig(int gate);
        for (int a = 1; a < SEARCH_LEN; a++)
            if (int'(mem[a-1]) < gate && int'(mem[a]) >= gate) return a;
        return -1;
    endfunction

    function automatic int model_addr(int trig, int x, int d);
        int de;
        de = (d == 0) ? 1 : d;
        return (trig + x * de) % SAMPLING_NUM;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_system);
        #1;
    endtask

    task automatic send(input bit req, input int x, input int d, input bit fs);
        bit acc;
        acc = req && !fs && m_serve && (x < H_ACTIVE);
        bus.Col_Req     = req;
        bus.Col_X       = 11'(x);
        bus.Decim       = 4'(d);
        bus.Frame_Start = fs;
        if (acc) begin
            m_addr       = model_addr(m_trig, x, d);
            m_addr_known = 1'b1;
            exp_q.push_back({32'(cyc + SERVE_LAT), mem[m_addr]});
        end
        tick();
        bus.Col_Req     = 1'b0;
        bus.Frame_Start = 1'b0;
        if (fs) begin
            exp_q.delete();
            m_serve = 1'b0;
            check("fs_read_addr_zero", bus.Read_Addr, 0);
            check("fs_ready_drop", bus.Ready, 0);
            check("fs_sample_valid_drop", bus.Sample_Valid, 0);
            check("fs_trig_found_hold", bus.Trig_Found, m_found);
            m_addr_known = 1'b0;
        end else begin
            if (m_addr_known) check("read_addr", bus.Read_Addr, m_addr);
            check("ready", bus.Ready, m_serve);
        end
    endtask

    task automatic start_search(input int gate);
        bus.Trigger_Gate = 8'(gate);
        m_pend = find_trig(gate);
        send(1'b0, 0, 1, 1'b1);
    endtask

    task automatic wait_search(input int n0);
        int  n;
        bit  seen;
        n    = n0;
        seen = 1'b0;
        while (n <= SEARCH_BOUND) begin
            if (bus.Ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check("search_done_in_bound", seen, 1);
        m_found      = (m_pend >= 0);
        m_trig       = m_found ? m_pend : 0;
        m_serve      = 1'b1;
        m_addr_known = 1'b0;
        check("trig_found", bus.Trig_Found, m_found);
    endtask

    task automatic do_reset(input bit with_fs);
        Rst = 1'b1;
        bus.Frame_Start = with_fs;
        bus.Col_Req     = 1'b1;
        tick();
        Rst = 1'b0;
        bus.Frame_Start = 1'b0;
        bus.Col_Req     = 1'b0;
        exp_q.delete();
        m_serve = 1'b0;
        m_found = 1'b0;
        m_addr  = 0;
        m_addr_known = 1'b1;
        check("rst_read_addr", bus.Read_Addr, 0);
        check("rst_sample_out", bus.Sample_Out, 0);
        check("rst_sample_valid", bus.Sample_Valid, 0);
        check("rst_ready", bus.Ready, 0);
        check("rst_trig_found", bus.Trig_Found, 0);
        check("rst_state_idle", dbg_state, 0);
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < SAMPLING_NUM; a++) mem[a] = 8'(a % 256);
    endtask

    // ---------------- table-driven serve vectors ----------------
    typedef struct {
        bit req;
        int x;
        int d;
        bit acc;
        int addr;
        int samp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Ramp RAM, trigger at 100: address = 100 + x*max(d,1), sample = address mod 256.
        vecs[0]  = '{1'b1,    0,  2, 1'b1,   100, 100};
        vecs[1]  = '{1'b1,    1,  2, 1'b1,   102, 102};
        vecs[2]  = '{1'b1,    2,  2, 1'b1,   104, 104};
        vecs[3]  = '{1'b1,    5,  0, 1'b1,   105, 105};
        vecs[4]  = '{1'b1, 1280,  3, 1'b0,   105,   0};
        vecs[5]  = '{1'b1,   10,  1, 1'b1,   110, 110};
        vecs[6]  = '{1'b0,    7,  4, 1'b0,   110,   0};
        vecs[7]  = '{1'b1, 1279, 15, 1'b1, 19285,  85};
        vecs[8]  = '{1'b1, 1000,  7, 1'b1,  7100, 188};
        vecs[9]  = '{1'b1, 2047,  1, 1'b0,  7100,   0};
        vecs[10] = '{1'b1, 1279,  1, 1'b1,  1379,  99};

        bus.Frame_Start  = 1'b0;
        bus.Trigger_Gate = 8'd0;
        bus.Decim        = 4'd0;
        bus.Col_Req      = 1'b0;
        bus.Col_X        = 11'd0;
        m_serve = 1'b0; m_found = 1'b0; m_trig = 0; m_addr = 0; m_addr_known = 1'b1; m_pend = -1;
        fill_ramp();
        tick();
        tick();
        do_reset(1'b0);

        // IDLE ignores column requests.
        send(1'b1, 5, 2, 1'b0);
        send(1'b1, 9, 1, 1'b0);

        // Ramp trigger at address 100.
        start_search(100);
        wait_search(1);

        for (int i = 0; i < 11; i++) begin
            bus.Col_Req = vecs[i].req;
            bus.Col_X   = 11'(vecs[i].x);
            bus.Decim   = 4'(vecs[i].d);
            if (vecs[i].acc) exp_q.push_back({32'(cyc + SERVE_LAT), 8'(vecs[i].samp)});
            tick();
            check($sformatf("vec%0d_addr", i), bus.Read_Addr, vecs[i].addr);
        end
        bus.Col_Req  = 1'b0;
        m_addr       = vecs[10].addr;
        m_addr_known = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 0, 1, 1'b0);

        // Frame_Start with Col_Req in SERVE: in-flight and same-cycle requests dropped.
        send(1'b1, 3, 1, 1'b0);
        exp_q.delete();
        send(1'b1, 4, 1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rescan_addr", bus.Read_Addr, k);
        end
        wait_search(4);

        // Frame_Start mid-SEARCH restarts from address 0.
        start_search(100);
        for (int k = 0; k < 20; k++) tick();
        start_search(100);
        wait_search(1);
        send(1'b1, 0, 1, 1'b0);

        // No crossing: flat RAM below the gate, Decim 0 treated as 1.
        for (int a = 0; a < SAMPLING_NUM; a++) mem[a] = 8'd50;
        start_search(100);
        wait_search(1);
        send(1'b1, 5, 0, 1'b0);
        check("flat_addr_const", bus.Read_Addr, 5);
        send(1'b1, 1280, 1, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b0, 0, 1, 1'b0);

        // Crossing at the last searched address and address wrap.
        for (int a = 0; a < SAMPLING_NUM; a++) mem[a] = 8'((a * 7) % 97);
        mem[SEARCH_LEN-1] = 8'd200;
        start_search(100);
        wait_search(1);
        send(1'b1, 1279, 15, 1'b0);
        check("wrap_addr_const", bus.Read_Addr, 3184);
        for (int i = 0; i < 4; i++) send(1'b0, 0, 1, 1'b0);

        // Reset mid-SEARCH, then mid-SERVE pipeline with Frame_Start overridden.
        fill_ramp();
        start_search(100);
        for (int k = 0; k < 50; k++) tick();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 7, 1, 1'b0);
        start_search(100);
        wait_search(1);
        send(1'b1, 1, 1, 1'b0);
        send(1'b1, 2, 1, 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 0, 1, 1'b0);
            check("post_rst_no_valid", bus.Sample_Valid, 0);
        end

        // Random frames against the reference model.
        for (int r = 0; r < 4; r++) begin
            int gate;
            for (int a = 0; a < SAMPLING_NUM; a++)
                mem[a] = (r == 2) ? 8'($urandom_range(0, 120)) : 8'($urandom_range(0, 255));
            if (r == 0)      gate = 0;
            else if (r == 2) gate = int'($urandom_range(110, 200));
            else             gate = int'($urandom_range(1, 255));
            start_search(gate);
            wait_search(1);
            for (int i = 0; i < 60; i++)
                send($urandom_range(0, 3) != 0, int'($urandom_range(0, 1300)),
                     int'($urandom_range(0, 15)), 1'b0);
        end

        for (int i = 0; i < 6; i++) send(1'b0, 0, 1, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
